// File: rtl/pulse_counter_if.sv
// Pulse-link receive bundle: line input, clear strobe and burst results.
// master drives the line and Clear; slave is the counter.
interface pulse_counter_if;
  logic        PulseIn;
  logic        Clear;
  logic [9:0]  PulseCnt;
  logic [14:0] Period;
  logic        Busy;
  logic        Done;
  logic        Glitch;
  logic        Ovf;

  modport master (
    output PulseIn, Clear,
    input  PulseCnt, Period, Busy,
    input  Done, Glitch, Ovf
  );

  modport slave (
    input  PulseIn, Clear,
    output PulseCnt, Period, Busy,
    output Done, Glitch, Ovf
  );
endinterface

// File: rtl/pulse_counter.sv
// Step-pulse receiver: counts falling edges, measures period,
// flags glitches/overflow and ends a burst after a quiet interval.
module pulse_counter #(
  parameter int TIMEOUT  = 100,
  parameter int MIN_HALF = 2
) (
  input logic            sysclk,
  input logic            rst,
  pulse_counter_if.slave pc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [14:0] TO   = 15'(TIMEOUT);
  localparam logic [14:0] MH   = 15'(MIN_HALF);
  localparam logic [9:0]  CMAX = 10'd1023;

  logic        s1, s2, s3;
  logic        fall, rise;
  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [14:0] per_q, per_d;
  logic [14:0] gap_q, gap_d, gap_inc;
  logic [14:0] run_q, run_d;
  logic        glitch_q, glitch_d;
  logic        ovf_q, ovf_d;
  logic        busy_q, done_q;

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  assign gap_inc = (gap_q >= TO) ? TO
                 : gap_q + 15'd1;

  // Synchronizer is deliberately immune to Clear.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= pc.PulseIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      gap_q    <= '0;
      run_q    <= '0;
      glitch_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      gap_q    <= gap_d;
      run_q    <= run_d;
      glitch_q <= glitch_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_d == ACTIVE);
      done_q   <= (state_d == DONE);
    end
  end

  // Quiet interval ends on the cycle gap reaches TIMEOUT,
  // but only once the line is back high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall) state_d = ACTIVE;
      ACTIVE:  if (gap_inc == TO && s2)
                 state_d = DONE;
      DONE:    if (fall) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
    if (pc.Clear) state_d = IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q;
    per_d    = per_q;
    gap_d    = gap_inc;
    glitch_d = glitch_q;
    ovf_d    = ovf_q;
    if (rise | fall)
      run_d = 15'd1;
    else if (run_q >= MH)
      run_d = MH;
    else
      run_d = run_q + 15'd1;

    unique case (state_q)
      ACTIVE: begin
        if ((rise | fall) && run_q < MH)
          glitch_d = 1'b1;
        if (fall) begin
          cnt_d = (cnt_q == CMAX) ? CMAX
                : cnt_q + 10'd1;
          ovf_d = ovf_q | (cnt_q == CMAX);
          per_d = gap_q;
          gap_d = 15'd1;
        end
      end
      default: begin
        if (fall) begin
          cnt_d = 10'd1;
          gap_d = 15'd1;
        end
      end
    endcase

    if (pc.Clear) begin
      cnt_d    = '0;
      per_d    = '0;
      gap_d    = '0;
      run_d    = '0;
      glitch_d = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  assign pc.PulseCnt = cnt_q;
  assign pc.Period   = per_q;
  assign pc.Busy     = busy_q;
  assign pc.Done     = done_q;
  assign pc.Glitch   = glitch_q;
  assign pc.Ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_counter.sv
// Scoreboard bench for pulse_counter: bursts described as low/high
// run lengths; expected results checked when Done rises.
`timescale 1ns/1ps
module tb_pulse_counter;

  localparam int TIMEOUT  = 100;
  localparam int MIN_HALF = 2;

  logic sysclk = 1'b0;
  logic rst    = 1'b0;

  pulse_counter_if ifc();

  pulse_counter #(
    .TIMEOUT (TIMEOUT),
    .MIN_HALF(MIN_HALF)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .pc    (ifc)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int cnt;
    int period;
    int glitch;
    int ovf;
    int edge_at;
  } exp_t;

  exp_t q[$];
  int   bl[$];
  int   bh[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;
  int   m_period = 0;
  int   m_glitch = 0;
  int   m_ovf    = 0;
  logic prev_done = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d @edge %0d",
               name, act, exp, edge_n);
    end
  endfunction

  function automatic void model_reset();
    m_period = 0;
    m_glitch = 0;
    m_ovf    = 0;
  endfunction

  initial forever begin
    @(posedge sysclk);
    edge_n++;
  end

  // Monitor: every rising Done retires one expected burst.
  initial begin
    exp_t e;
    forever begin
      @(posedge sysclk);
      #1;
      if (ifc.Done && !prev_done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("done_edge", edge_n, e.edge_at);
          chk("cnt", int'(ifc.PulseCnt), e.cnt);
          chk("period", int'(ifc.Period), e.period);
          chk("glitch", int'(ifc.Glitch), e.glitch);
          chk("ovf", int'(ifc.Ovf), e.ovf);
          chk("busy_at_done", int'(ifc.Busy), 0);
        end
      end
      prev_done = ifc.Done;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic lo_phase(input int lo, output int k);
    @(negedge sysclk);
    ifc.PulseIn = 1'b0;
    k = edge_n + 1;
    for (int i = 1; i < lo; i++) begin
      @(negedge sysclk);
      if (lo > 300 && i == 250) begin
        chk("held_busy", int'(ifc.Busy), 1);
        chk("held_done", int'(ifc.Done), 0);
      end
    end
  endtask

  task automatic hi_phase(input int hi);
    @(negedge sysclk);
    ifc.PulseIn = 1'b1;
    repeat (hi - 1) @(negedge sysclk);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_cnt"}, int'(ifc.PulseCnt), 0);
    chk({tag, "_period"}, int'(ifc.Period), 0);
    chk({tag, "_busy"}, int'(ifc.Busy), 0);
    chk({tag, "_done"}, int'(ifc.Done), 0);
    chk({tag, "_glitch"}, int'(ifc.Glitch), 0);
    chk({tag, "_ovf"}, int'(ifc.Ovf), 0);
  endtask

  // Drive bl/bh as one burst; last bh entry is replaced by idle.
  task automatic run_burst();
    int   n;
    int   k;
    int   d1;
    int   d2;
    exp_t e;
    n = bl.size();
    for (int i = 0; i < n; i++) begin
      if (bl[i] < MIN_HALF) m_glitch = 1;
      if (i < n - 1 && bh[i] < MIN_HALF) m_glitch = 1;
    end
    if (n > 1023) m_ovf = 1;
    if (n >= 2) m_period = bl[n-2] + bh[n-2];
    e.cnt    = (n > 1023) ? 1023 : n;
    e.period = m_period;
    e.glitch = m_glitch;
    e.ovf    = m_ovf;
    k = 0;
    for (int i = 0; i < n; i++) begin
      lo_phase(bl[i], k);
      if (i < n - 1) hi_phase(bh[i]);
    end
    d1 = k + TIMEOUT + 1;
    d2 = k + bl[n-1] + 2;
    e.edge_at = (d1 > d2) ? d1 : d2;
    q.push_back(e);
    hi_phase(TIMEOUT + 20);
  endtask

  task automatic uniform_burst(input int n, input int lo,
                               input int hi);
    bl.delete();
    bh.delete();
    for (int i = 0; i < n; i++) begin
      bl.push_back(lo);
      bh.push_back(hi);
    end
    run_burst();
  endtask

  task automatic rand_burst();
    int n;
    bl.delete();
    bh.delete();
    n = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) begin
      bl.push_back($urandom_range(1, 30));
      bh.push_back($urandom_range(1, 30));
    end
    run_burst();
  endtask

  initial begin
    int k;
    ifc.PulseIn = 1'b1;
    ifc.Clear   = 1'b0;
    repeat (3) @(negedge sysclk);
    check_zero("reset");
    rst = 1'b1;
    repeat (5) @(negedge sysclk);

    uniform_burst(5, 11, 11);

    bl = '{11, 11, 11, 1};
    bh = '{11, 11, 11, 11};
    run_burst();

    repeat (4) rand_burst();

    // Clear lands in the same cycle the 8th fall is seen.
    for (int i = 0; i < 7; i++) begin
      lo_phase(6, k);
      hi_phase(6);
    end
    @(negedge sysclk);
    ifc.PulseIn = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    ifc.Clear = 1'b1;
    @(posedge sysclk);
    #1;
    check_zero("clear");
    @(negedge sysclk);
    ifc.Clear = 1'b0;
    repeat (3) @(negedge sysclk);
    model_reset();
    hi_phase(20);
    uniform_burst(1, 5, 5);

    for (int i = 0; i < 3; i++) begin
      lo_phase(5, k);
      hi_phase(5);
    end
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge sysclk);
    rst = 1'b1;
    model_reset();
    uniform_burst(2, 7, 9);

    bl = '{10, 500};
    bh = '{10, 10};
    run_burst();

    uniform_burst(1030, 2, 2);

    repeat (3) rand_burst();

    repeat (20) @(negedge sysclk);
    chk("queue_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_counter.md
# pulse_counter

Receiving end of the step-pulse link driven by the pulse generator: counts falling edges on an idle-high pulse train, measures the edge-to-edge period, flags glitches and overflow, and declares end-of-burst after a quiet interval. It sits on the input side of a loopback or downstream board, so firmware and the verification bench can confirm that the requested pulse count and period actually arrived.

## Interface
- `TIMEOUT`, default 100: number of idle cycles after the last falling edge that ends a burst; range 2..32767.
- `MIN_HALF`, default 2: minimum legal high or low run length, in sysclk cycles; range 1..TIMEOUT.
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `PulseIn`  in  1  asynchronous pulse train; idles high; one pulse = one high-to-low transition.
- `Clear`  in  1  synchronous, active-high; abandons the current burst and zeroes all results.
- `PulseCnt`  out  10  falling edges counted in the current or last burst.
- `Period`  out  15  cycles between the two most recent falling edges.
- `Busy`  out  1  high while a burst is in progress.
- `Done`  out  1  level; high once a burst has ended, until the next burst starts or `Clear`.
- `Glitch`  out  1  sticky; a run shorter than `MIN_HALF` was seen during a burst.
- `Ovf`  out  1  sticky; the count saturated.

## Operation
- Input path:
  - Two-flop synchronizer `s1`, `s2`, followed by history flop `s3`; all three reset to 1.
  - `fall = s3 & ~s2`; `rise = ~s3 & s2`.
- FSM states: IDLE, ACTIVE, DONE. Reset state is IDLE.
  - IDLE, on `fall`: `PulseCnt`=1, gap=1, go to ACTIVE.
  - ACTIVE, on `fall`: `PulseCnt`+1, `Period`=gap, gap=1.
  - ACTIVE, no `fall`: gap+1, saturating at `TIMEOUT`.
  - ACTIVE, gap==`TIMEOUT` and `s2`==1: go to DONE.
  - ACTIVE with the line held low: stays ACTIVE indefinitely; no `Done`.
  - DONE, on `fall`: start a new burst exactly as from IDLE. `Period` and `Glitch` are kept; `Done` drops.
- `Busy` = (state==ACTIVE). `Done` = (state==DONE). Both are registered.
- Saturation: `PulseCnt` stops at 1023. A further `fall` at 1023 sets `Ovf`; `Period` still updates.
- Glitch detection:
  - A run counter counts cycles since the last `rise` or `fall`, saturating at `MIN_HALF`.
  - In ACTIVE, a `rise` or `fall` seen with run count < `MIN_HALF` sets `Glitch`.
  - The edge is still counted.
- `Clear` has priority over every event in the same cycle.
  - Goes to IDLE.
  - Zeroes `PulseCnt`, `Period`, `Glitch`, `Ovf`, `Busy`, `Done`, gap and the run counter.
  - The synchronizer is not touched.
- Widths: gap and run counters are 15 bits and never wrap.

## Timing
- Reset values: all outputs 0; synchronizer 1; state IDLE.
- `rst` asserted mid-burst: immediate return to reset values. The first `fall` after release starts a fresh burst.
- Edge latency:
  - Let k be the rising edge at which `s1` first samples `PulseIn` low.
  - `fall` is asserted after edge k+1.
  - `PulseCnt`, `Period`, `Busy` and the state update at edge k+2.
- `Done` asserts `TIMEOUT`-1 cycles after the cycle in which the last `fall` was registered, provided the line is high.
- Period convention: a source that toggles every N+1 cycles gives `Period` = 2(N+1).
- Minimum resolvable pulse: 1 cycle low / 1 cycle high after synchronization. Shorter pulses may be lost, and are flagged only when `MIN_HALF`>1.

## Test plan
- 5 pulses, 11 cycles high / 11 cycles low, `TIMEOUT`=100 -> `PulseCnt`=5, `Period`=22, `Busy` for the whole burst, `Done`=1 and `Busy`=0 exactly 99 cycles after the 5th registered `fall`. `Glitch` and `Ovf` stay 0.
- 3 normal pulses, then a 1-cycle low, with `MIN_HALF`=2 -> `PulseCnt`=4, `Glitch`=1, held through the following `Done`.
- `Clear` pulsed mid-burst after 7 pulses, in the same cycle as a `fall` -> all outputs 0, state IDLE. The next `fall` gives `PulseCnt`=1.
- `rst` low for 1 cycle mid-burst, then 2 pulses -> outputs zero during reset, then `PulseCnt`=2 and `Done` after timeout.
- 1030 pulses at period 4 -> `PulseCnt`=1023, `Ovf`=1, `Period`=4, then `Done`.
- Line held low for 500 cycles after 2 pulses -> `Busy` stays 1 and `Done` stays 0. After release high, `Done` rises 99 cycles after the 2nd registered `fall` or on release, whichever is later.
